// File: rtl/pcq_dbg_trace_ctrl.sv
// Trace sequencer for the PC debug mux: arm / trigger / post-trigger / done control.
// Optional arm-to-trigger timestamp counter is built when PCQ_DBG_TRIG_TIMESTAMP_EN is defined.
module pcq_dbg_trace_ctrl #(
  parameter int TRACE_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_arm,
  input  logic                   cmd_stop,
  input  logic [2:0]             cfg_group_sel,
  input  logic [7:0]             cfg_mux_misc,
  input  logic                   cfg_rotate_en,
  input  logic [CNT_WIDTH-1:0]   cfg_dwell,
  input  logic [TRACE_WIDTH-1:0] cfg_trig_mask,
  input  logic [TRACE_WIDTH-1:0] cfg_trig_pattern,
  input  logic [CNT_WIDTH-1:0]   cfg_post_count,
  input  logic [TRACE_WIDTH-1:0] trace_bus_in,
  output logic [10:0]            debug_mux_ctrls,
  output logic                   trace_bus_enable,
  output logic                   trig_hit,
  output logic [2:0]             trig_group,
  output logic [CNT_WIDTH-1:0]   trig_timestamp,
  output logic                   done,
  output logic [1:0]             state
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ARMED = 2'b01;
  localparam logic [1:0] S_POST  = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;
  localparam logic [1:0] SETTLE_RELOAD = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [2:0]             group_q, group_d;
  logic [7:0]             misc_q, misc_d;
  logic [CNT_WIDTH-1:0]   dwell_q, dwell_d;
  logic [1:0]             settle_q, settle_d;
  logic [CNT_WIDTH-1:0]   post_q, post_d;
  logic                   trig_hit_q, trig_hit_d;
  logic [2:0]             trig_group_q, trig_group_d;

  // Configuration captured on arm; data-only, never reset.
  logic [TRACE_WIDTH-1:0] mask_q, pattern_q;
  logic [CNT_WIDTH-1:0]   dwell_cfg_q, post_cfg_q;
  logic                   rotate_q;

  logic arm_acc, match, fire;

  assign arm_acc = cmd_arm && !cmd_stop;
  assign match   = ((trace_bus_in ^ pattern_q) & mask_q) == '0;
  assign fire    = !cmd_stop && !cmd_arm && (state_q == S_ARMED) && (settle_q == 2'd0) && match;

  always_comb begin
    state_d      = state_q;
    group_d      = group_q;
    misc_d       = misc_q;
    dwell_d      = dwell_q;
    settle_d     = settle_q;
    post_d       = post_q;
    trig_hit_d   = 1'b0;
    trig_group_d = trig_group_q;
    if (cmd_stop) begin
      state_d = S_IDLE;
    end else if (cmd_arm) begin
      state_d  = S_ARMED;
      group_d  = cfg_group_sel;
      misc_d   = cfg_mux_misc;
      dwell_d  = cfg_dwell;
      settle_d = SETTLE_RELOAD;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (fire) begin
            state_d      = S_POST;
            trig_hit_d   = 1'b1;
            trig_group_d = group_q;
            post_d       = post_cfg_q;
          end else begin
            if (settle_q != 2'd0) settle_d = settle_q - 2'd1;
            // Group advance re-opens the settle window for the new mux path.
            if (rotate_q) begin
              if (dwell_q == '0) begin
                group_d  = group_q + 3'd1;
                dwell_d  = dwell_cfg_q;
                settle_d = SETTLE_RELOAD;
              end else begin
                dwell_d = dwell_q - CNT_WIDTH'(1);
              end
            end
          end
        end
        S_POST: begin
          if (post_q == '0) state_d = S_DONE;
          else              post_d  = post_q - CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      group_q      <= '0;
      misc_q       <= '0;
      dwell_q      <= '0;
      settle_q     <= '0;
      post_q       <= '0;
      trig_hit_q   <= 1'b0;
      trig_group_q <= '0;
    end else begin
      state_q      <= state_d;
      group_q      <= group_d;
      misc_q       <= misc_d;
      dwell_q      <= dwell_d;
      settle_q     <= settle_d;
      post_q       <= post_d;
      trig_hit_q   <= trig_hit_d;
      trig_group_q <= trig_group_d;
    end
  end

  always_ff @(posedge clk) begin
    if (arm_acc) begin
      mask_q      <= cfg_trig_mask;
      pattern_q   <= cfg_trig_pattern;
      dwell_cfg_q <= cfg_dwell;
      post_cfg_q  <= cfg_post_count;
      rotate_q    <= cfg_rotate_en;
    end
  end

`ifdef PCQ_DBG_TRIG_TIMESTAMP_EN
  logic [CNT_WIDTH-1:0] ts_q, trig_ts_q;

  // Latched value counts edges from arm up to and including the trigger edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q      <= '0;
      trig_ts_q <= '0;
    end else if (arm_acc) begin
      ts_q      <= '0;
      trig_ts_q <= '0;
    end else if (!cmd_stop && state_q == S_ARMED) begin
      ts_q <= ts_q + CNT_WIDTH'(1);
      if (fire) trig_ts_q <= ts_q + CNT_WIDTH'(1);
    end
  end

  assign trig_timestamp = trig_ts_q;
`else
  assign trig_timestamp = '0;
`endif

  assign debug_mux_ctrls  = {misc_q, group_q};
  assign trace_bus_enable = (state_q == S_ARMED) || (state_q == S_POST);
  assign done             = (state_q == S_DONE);
  assign trig_hit         = trig_hit_q;
  assign trig_group       = trig_group_q;
  assign state            = state_q;

endmodule

// File: tb/tb_pcq_dbg_trace_ctrl.sv
// Directed bench for pcq_dbg_trace_ctrl: triggers, post count, rotation, collisions, reset.
module tb_pcq_dbg_trace_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_arm = 1'b0, cmd_stop = 1'b0;
  logic [2:0]  cfg_group_sel = '0;
  logic [7:0]  cfg_mux_misc = '0;
  logic        cfg_rotate_en = 1'b0;
  logic [15:0] cfg_dwell = '0, cfg_post_count = '0;
  logic [31:0] cfg_trig_mask = '0, cfg_trig_pattern = '0, trace_bus_in = '0;
  logic [10:0] debug_mux_ctrls;
  logic        trace_bus_enable, trig_hit, done;
  logic [2:0]  trig_group;
  logic [15:0] trig_timestamp;
  logic [1:0]  state;

  int checks = 0, errors = 0;

  pcq_dbg_trace_ctrl #(.TRACE_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cmd_arm(cmd_arm), .cmd_stop(cmd_stop),
    .cfg_group_sel(cfg_group_sel), .cfg_mux_misc(cfg_mux_misc),
    .cfg_rotate_en(cfg_rotate_en), .cfg_dwell(cfg_dwell),
    .cfg_trig_mask(cfg_trig_mask), .cfg_trig_pattern(cfg_trig_pattern),
    .cfg_post_count(cfg_post_count), .trace_bus_in(trace_bus_in),
    .debug_mux_ctrls(debug_mux_ctrls), .trace_bus_enable(trace_bus_enable),
    .trig_hit(trig_hit), .trig_group(trig_group), .trig_timestamp(trig_timestamp),
    .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [2:0] g, input logic [7:0] misc, input logic rot,
                        input logic [15:0] dw, input logic [31:0] msk, input logic [31:0] pat,
                        input logic [15:0] pc);
    cfg_group_sel = g; cfg_mux_misc = misc; cfg_rotate_en = rot; cfg_dwell = dw;
    cfg_trig_mask = msk; cfg_trig_pattern = pat; cfg_post_count = pc;
    cmd_arm = 1'b1;
    step();
    cmd_arm = 1'b0;
  endtask

  logic [15:0] exp_ts;
  logic [2:0]  rot_seq [10];
  int hits, npost;

  initial begin
    rot_seq = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd1};

    // Reset state
    step(); step();
    chk("rst_state", state, 2'b00);
    chk("rst_dmc", debug_mux_ctrls, 11'h000);
    chk("rst_tbe", trace_bus_enable, 1'b0);
    chk("rst_hit", trig_hit, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tgroup", trig_group, 3'd0);
    chk("rst_ts", trig_timestamp, 16'd0);
    rst = 1'b0;
    step();

    // Static trigger at the 10th edge after arm, post count 4
    trace_bus_in = 32'h0000_1234;
    do_arm(3'd3, 8'h5A, 1'b0, 16'd0, 32'hFFFF_0000, 32'hABCD_0000, 16'd4);
    chk("arm_state", state, 2'b01);
    chk("arm_tbe", trace_bus_enable, 1'b1);
    chk("arm_dmc", debug_mux_ctrls, 11'h2D3);
    hits = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (trig_hit) hits++;
    end
    chk("static_early_hits", hits, 0);
    trace_bus_in = 32'hABCD_1234;
    step();
    chk("static_hit", trig_hit, 1'b1);
    chk("static_state_post", state, 2'b10);
    chk("static_tgroup", trig_group, 3'd3);
`ifdef PCQ_DBG_TRIG_TIMESTAMP_EN
    exp_ts = 16'd10;
`else
    exp_ts = 16'd0;
`endif
    chk("static_ts", trig_timestamp, exp_ts);
    npost = 1; hits = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (trig_hit) hits++;
      if (state == 2'b10) npost++;
      else break;
    end
    chk("post_hit_once", hits, 0);
    chk("post_cycles", npost, 5);
    chk("done_state", state, 2'b11);
    chk("done_level", done, 1'b1);
    chk("done_tbe", trace_bus_enable, 1'b0);
    chk("done_dmc_hold", debug_mux_ctrls, 11'h2D3);
    step();
    chk("done_hold_ts", trig_timestamp, exp_ts);

    // Re-arm from DONE with mask 0: fires 3 edges after arm
    trace_bus_in = 32'hDEAD_BEEF;
    do_arm(3'd1, 8'h00, 1'b0, 16'd0, 32'h0, 32'h0, 16'd0);
    chk("rearm_state", state, 2'b01);
    chk("rearm_done_clr", done, 1'b0);
    step();
    chk("settle1_nohit", trig_hit, 1'b0);
    step();
    chk("settle2_nohit", trig_hit, 1'b0);
    step();
    chk("settle_fire", trig_hit, 1'b1);
    chk("settle_tgroup", trig_group, 3'd1);

    // Match only during settle cycles is ignored
    trace_bus_in = 32'h1234_5678;
    do_arm(3'd2, 8'h00, 1'b0, 16'd0, 32'hFFFF_FFFF, 32'h1234_5678, 16'd0);
    step(); step();
    trace_bus_in = 32'h0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (trig_hit) hits++;
    end
    chk("settle_ignored", hits, 0);
    chk("settle_still_armed", state, 2'b01);

    // Stop returns to IDLE
    cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
    chk("stop_state", state, 2'b00);
    chk("stop_tbe", trace_bus_enable, 1'b0);

    // Rotation with wrap, never matching
    trace_bus_in = 32'h0;
    do_arm(3'd6, 8'h00, 1'b1, 16'd2, 32'hFFFF_FFFF, 32'h0000_0001, 16'd0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("rot_group%0d", i), debug_mux_ctrls[2:0], rot_seq[i]);
      if (i < 9) step();
    end

    // Arm and stop together while ARMED: stop wins
    cfg_group_sel = 3'd4;
    cmd_arm = 1'b1; cmd_stop = 1'b1;
    step();
    cmd_arm = 1'b0; cmd_stop = 1'b0;
    chk("armstop_state", state, 2'b00);
    step();
    chk("armstop_stays_idle", state, 2'b00);

    // Match coincides with dwell expiry: trigger wins, group holds
    do_arm(3'd6, 8'h00, 1'b1, 16'd2, 32'h0, 32'h0, 16'd7);
    step(); step(); step();
    chk("coll_hit", trig_hit, 1'b1);
    chk("coll_tgroup", trig_group, 3'd6);
    chk("coll_group_held", debug_mux_ctrls[2:0], 3'd6);
`ifdef PCQ_DBG_TRIG_TIMESTAMP_EN
    chk("coll_ts", trig_timestamp, 16'd3);
`else
    chk("coll_ts", trig_timestamp, 16'd0);
`endif
    step();
    chk("coll_post_group_frozen", debug_mux_ctrls[2:0], 3'd6);

    // Arm while in POST restarts
    do_arm(3'd2, 8'h00, 1'b0, 16'd0, 32'h0, 32'h0, 16'd9);
    chk("restart_state", state, 2'b01);
    chk("restart_group", debug_mux_ctrls[2:0], 3'd2);
    step(); step(); step();
    chk("restart_hit", trig_hit, 1'b1);
    chk("restart_post", state, 2'b10);

    // Asynchronous reset mid-POST
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_state", state, 2'b00);
    chk("arst_dmc", debug_mux_ctrls, 11'h000);
    chk("arst_tbe", trace_bus_enable, 1'b0);
    chk("arst_tgroup", trig_group, 3'd0);
    chk("arst_ts", trig_timestamp, 16'd0);
    step();
    rst = 1'b0;
    step();
    chk("arst_idle_after", state, 2'b00);
    do_arm(3'd5, 8'h11, 1'b0, 16'd0, 32'h0, 32'h0, 16'd0);
    chk("post_rst_arm_dmc", debug_mux_ctrls, 11'h08D);
    step(); step(); step();
    chk("post_rst_hit", trig_hit, 1'b1);
    chk("post_rst_tgroup", trig_group, 3'd5);
    step();
    step();
    chk("post_rst_done", done, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
